// File: rtl/adder_share_ctrl.sv
// Round-robin controller that time-shares one external DW-bit adder between two
// requesters, building DW*NPASS-bit add/sub results one slice per cycle, LSB first.
module adder_share_ctrl #(
    parameter  int DW    = 16,
    parameter  int NPASS = 2,
    localparam int OW    = DW * NPASS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_sub,
    input  logic [2*OW-1:0] req_a,
    input  logic [2*OW-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [OW-1:0]   rsp_sum,
    output logic            rsp_cout,
    output logic            rsp_ovf,
    output logic            busy,
    output logic [DW-1:0]   adder_a,
    output logic [DW-1:0]   adder_b,
    output logic            adder_cin,
    input  logic [DW-1:0]   adder_sum,
    input  logic            adder_cout
);

    localparam int PW = (NPASS > 1) ? $clog2(NPASS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t          state_reg;
    logic            rr_reg;
    logic [PW-1:0]   pass_reg;
    logic            carry_reg;
    logic            sub_reg;
    logic            id_reg;
    logic [OW-1:0]   a_reg;
    logic [OW-1:0]   b_reg;
    logic [DW-1:0]   sum_slice_reg [NPASS];

    logic            grant;
    logic            accept;
    logic            in_exec;
    logic            in_rsp;
    logic            last_pass;
    logic [DW-1:0]   a_slice [NPASS];
    logic [DW-1:0]   b_slice [NPASS];

    // rr only arbitrates a tie; a lone requester always wins
    assign grant     = (req_valid == 2'b11) ? rr_reg : req_valid[1];
    assign accept    = (state_reg == IDLE) && (|req_valid);
    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign in_exec   = (state_reg == EXEC);
    assign in_rsp    = (state_reg == RSP);
    assign last_pass = (pass_reg == PW'(NPASS - 1));

    generate
        for (genvar gi = 0; gi < NPASS; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[gi*DW +: DW];
            // subtraction is A + ~B + 1; the +1 enters as the initial carry
            assign b_slice[gi] = b_reg[gi*DW +: DW] ^ {DW{sub_reg}};
            assign rsp_sum[gi*DW +: DW] = sum_slice_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_slice_reg[gi] <= '0;
                end else if (in_exec && (pass_reg == PW'(gi))) begin
                    sum_slice_reg[gi] <= adder_sum;
                end
            end
        end
    endgenerate

    assign adder_a   = in_exec ? a_slice[pass_reg] : '0;
    assign adder_b   = in_exec ? b_slice[pass_reg] : '0;
    assign adder_cin = in_exec & carry_reg;

    assign rsp_valid = in_rsp;
    assign busy      = (state_reg != IDLE);
    assign rsp_id    = id_reg;
    assign rsp_cout  = in_rsp & carry_reg;
    assign rsp_ovf   = in_rsp
                     & (a_reg[OW-1] == (b_reg[OW-1] ^ sub_reg))
                     & (sum_slice_reg[NPASS-1][DW-1] != a_reg[OW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            pass_reg  <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            id_reg    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= grant ? req_a[2*OW-1:OW] : req_a[OW-1:0];
                        b_reg     <= grant ? req_b[2*OW-1:OW] : req_b[OW-1:0];
                        sub_reg   <= req_sub[grant];
                        id_reg    <= grant;
                        rr_reg    <= ~grant;
                        pass_reg  <= '0;
                        carry_reg <= req_sub[grant];
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    carry_reg <= adder_cout;
                    if (last_pass) begin
                        pass_reg  <= '0;
                        state_reg <= RSP;
                    end else begin
                        pass_reg  <= pass_reg + PW'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
